// File: rtl/pipe_stall_if.sv
// Pipeline-to-stall-controller bundle: hazard/handshake inputs from the core and
// the stall/flush/bubble controls returned to it. dbg_state mirrors the FSM state.
interface pipe_stall_if #(
  parameter int REG_W = 5
) ();
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rd;
  logic             id_md_start;
  logic             id_md_is_div;
  logic             id_jump;
  logic             imem_ready;
  logic             dmem_req;
  logic             dmem_ready;
  logic             full_stall;
  logic             jump_stall;
  logic             idex_bubble;
  logic             release_bubble;
  logic             md_busy;
  logic [2:0]       stall_cause;
  logic             dbg_state;

  // Handshake: the pipeline presents hazard and ready inputs for the current
  // cycle; the controller answers combinationally in the same cycle, and every
  // control output acts on the next rising clk edge.
  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
           id_md_start, id_md_is_div, id_jump, imem_ready, dmem_req, dmem_ready,
    input  full_stall, jump_stall, idex_bubble, release_bubble, md_busy,
           stall_cause, dbg_state
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
           id_md_start, id_md_is_div, id_jump, imem_ready, dmem_req, dmem_ready,
    output full_stall, jump_stall, idex_bubble, release_bubble, md_busy,
           stall_cause, dbg_state
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer: arbitrates memory wait, mul/div occupancy,
// load-use and jump redirect, and emits a registered post-stall release bubble.
module pipe_stall_ctrl #(
  parameter int REG_W   = 5,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic         clk,
  input  logic         rst,
  pipe_stall_if.slave  bus
);

  typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             jump_pend_q, jump_pend_d;
  logic             stall_q, stall_d;

  logic       mem_wait;
  logic       load_use;
  logic       md_wait;
  logic       full_stall;
  logic       jump_req;
  logic       jump_now;
  logic [2:0] cause;

  always_comb begin
    mem_wait   = !bus.imem_ready | (bus.dmem_req & !bus.dmem_ready);
    load_use   = bus.ex_mem_read & (bus.ex_rd != '0) &
                 ((bus.id_uses_rs & (bus.id_rs == bus.ex_rd)) |
                  (bus.id_uses_rt & (bus.id_rt == bus.ex_rd)));
    md_wait    = (state_q == MD_WAIT);
    full_stall = mem_wait | md_wait | load_use;
    jump_req   = bus.id_jump | jump_pend_q;
    jump_now   = jump_req & !full_stall;

    if (mem_wait)      cause = 3'd1;
    else if (md_wait)  cause = 3'd2;
    else if (load_use) cause = 3'd3;
    else if (jump_now) cause = 3'd4;
    else               cause = 3'd0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        // A start under stall is dropped; the held ID instruction re-issues it.
        if (bus.id_md_start && !full_stall) begin
          state_d = MD_WAIT;
          cnt_d   = bus.id_md_is_div ? DIV_LOAD : MUL_LOAD;
        end
      end
      MD_WAIT: begin
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = RUN;
    endcase
    // A jump seen while stalled survives until the first free cycle, where it drains.
    jump_pend_d = full_stall & jump_req;
    stall_d     = full_stall;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      jump_pend_q <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      jump_pend_q <= jump_pend_d;
      stall_q     <= stall_d;
    end
  end

  // Outputs are forced low for the whole reset window, even though the stall
  // terms themselves are combinational in the pipeline inputs.
  assign bus.full_stall     = !rst & full_stall;
  assign bus.jump_stall     = !rst & jump_now;
  assign bus.idex_bubble    = !rst & load_use & !mem_wait & !md_wait;
  assign bus.release_bubble = !rst & stall_q & !full_stall;
  assign bus.md_busy        = !rst & md_wait;
  assign bus.stall_cause    = rst ? 3'd0 : cause;
  assign bus.dbg_state      = state_q;

endmodule
